// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared op/state encodings and special-case constants for the RV32M divider
package div_unit_pkg;
    localparam int XLEN_DEF = 32;
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;
    localparam logic [XLEN_DEF-1:0] DIV0_QUO = '1;
    localparam logic [XLEN_DEF-1:0] OVF_QUO  = {1'b1, {(XLEN_DEF-1){1'b0}}};
endpackage

// File: rtl/cla_sub33.sv
// cla_sub33: (XLEN+1)-bit a-b from 4-bit carry-lookahead groups with group-level ripple
//  a, b  in   XLEN+1  minuend, subtrahend
//  diff  out  XLEN    low XLEN bits of a-b (top bit is zero whenever the divider keeps it)
//  cout  out  1       carry out; 1 means a >= b
module cla_sub33
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN:0]   a,
    input  logic [XLEN:0]   b,
    output logic [XLEN-1:0] diff,
    output logic            cout
);
    localparam int G = XLEN / 4;
    logic [XLEN:0]   bn, g, p;
    logic [XLEN+1:0] c;
    assign bn   = ~b;
    assign g    = a & bn;
    assign p    = a ^ bn;
    assign c[0] = 1'b1;
    for (genvar j = 0; j < G; j++) begin : grp
        localparam int k = 4 * j;
        assign c[k+1] = g[k] | (p[k] & c[k]);
        assign c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
        assign c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
                      | (p[k+2] & p[k+1] & p[k] & c[k]);
        assign c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
                      | (p[k+3] & p[k+2] & p[k+1] & g[k])
                      | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
    // the extra sign-extension bit is a lone ripple cell above the full groups
    assign c[XLEN+1] = g[XLEN] | (p[XLEN] & c[XLEN]);
    assign diff      = p[XLEN-1:0] ^ c[XLEN-1:0];
    assign cout      = c[XLEN+1];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
//  clk, rst   clock, synchronous active-high reset
//  start/op   request and operation (00 DIV, 01 DIVU, 10 REM, 11 REMU), sampled in IDLE
//  rs1/rs2    dividend/divisor, captured on the accepting edge
//  flush      aborts any in-flight operation without a done
//  busy/done  busy from accept through the done cycle; done is a one-cycle result pulse
//  result     quotient or remainder, held until the next done
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_e          state, state_n;
    logic [5:0]      cnt;
    logic [1:0]      op_r;
    logic [XLEN-1:0] rem, quo, dvs, diff, abs1, abs2;
    logic            neg_q, neg_r, cout, sgn, div0, ovf, accept, last;

    assign sgn    = (op == OP_DIV) || (op == OP_REM);
    assign div0   = rs2 == '0;
    assign ovf    = sgn && rs1 == OVF_QUO && rs2 == '1;
    assign abs1   = (sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    assign abs2   = (sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    // the done cycle already sits in IDLE but still counts as busy, so a start there is dropped
    assign accept = state == S_IDLE && start && !done && !flush;
    assign last   = cnt == 6'(XLEN - 1);
    assign busy   = state != S_IDLE || done;

    cla_sub33 #(.XLEN(XLEN)) u_sub (
        .a   ({rem, quo[XLEN-1]}),
        .b   ({1'b0, dvs}),
        .diff(diff),
        .cout(cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush)                          state_n = S_IDLE;
        else if (accept)                    state_n = (div0 || ovf) ? S_FIX : S_CALC;
        else if (state == S_CALC && last)   state_n = S_FIX;
        else if (state == S_FIX)            state_n = S_IDLE;
    end

    // special cases preload the final quo/rem and clear the sign flags so FIX passes them through
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            cnt    <= '0;
            op_r   <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            op_r  <= op;
            cnt   <= '0;
            dvs   <= abs2;
            quo   <= div0 ? DIV0_QUO : ovf ? OVF_QUO : abs1;
            rem   <= div0 ? rs1 : '0;
            neg_q <= sgn && !div0 && !ovf && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_r <= sgn && !div0 && !ovf && rs1[XLEN-1];
        end else if (!flush && state == S_CALC) begin
            cnt <= cnt + 6'd1;
            rem <= cout ? diff : {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], cout};
        end else if (!flush && state == S_FIX) begin
            result <= op_r[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
            done   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven directed checks of div_unit plus flush/start-while-busy/reset sequences
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk, rst, start, flush, busy, done;
    logic [1:0]  op;
    logic [31:0] rs1, rs2, result;
    int          checks, errors;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int n, c;
        logic [31:0] prev;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        rs1    = '0;
        rs2    = '0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,         33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,        32'd2,          33};
        vecs[2]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   33};
        vecs[3]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   33};
        vecs[4]  = '{OP_DIV,  32'd5,          32'd0,        32'hFFFFFFFF,   1};
        vecs[5]  = '{OP_REMU, 32'd5,          32'd0,        32'd5,          1};
        vecs[6]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000,   1};
        vecs[7]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF, 32'd0,          1};
        vecs[8]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   33};
        vecs[9]  = '{OP_REM,  32'd7,          32'hFFFFFFFE, 32'd1,          33};
        vecs[10] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   33};
        vecs[11] = '{OP_REMU, 32'hFFFFFFFF,   32'd10,       32'd5,          33};
        vecs[12] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF, 32'd0,          33};
        vecs[13] = '{OP_DIV,  32'hFFFFFFF8,   32'hFFFFFFFD, 32'd2,          33};
        vecs[14] = '{OP_REM,  32'hFFFFFFF8,   32'hFFFFFFFD, 32'hFFFFFFFE,   33};
        vecs[15] = '{OP_REM,  32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB,   1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp);
            chk($sformatf("v%0d_busy_in_done", i), {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
        end

        prev = vecs[15].exp;
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_result_held", result, prev);
        count_dones(40, c);
        chk("flush_no_done", c, 32'd0);
        chk("flush_result_still", result, prev);
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(n);
        chk("after_flush_latency", n, 32'd33);
        chk("after_flush_result", result, 32'd3);
        @(posedge clk);
        #1;

        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_DIVU;
        rs1   = 32'd50;
        rs2   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("busy_start_latency", n + 5, 32'd33);
        chk("busy_start_result", result, 32'd333);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_cycle_start_busy", {31'd0, busy}, 32'd0);
        count_dones(40, c);
        chk("done_cycle_start_ignored", c, 32'd0);
        chk("done_cycle_result_held", result, 32'd333);

        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        count_dones(40, c);
        chk("midrst_no_done", c, 32'd0);
        issue(OP_REMU, 32'd100, 32'd7);
        wait_done(n);
        chk("post_rst_latency", n, 32'd33);
        chk("post_rst_result", result, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
